fmul_seq_param: RTL

//  Parametrised, multi-cycle IEEE-754-style floating-point multiplier; successor of the fixed half-precision combinational FMul.

---
 rtl/fmul_seq_param.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/fmul_seq_param.sv
// Sequential floating-point multiplier: latency MAN_W+2 clocks from accept to out_Valid.
// Result is held until out_Ready; in_Ready is high only when idle. Define FMUL_ROUND_NEAREST_EVEN_EN for RNE rounding,
// otherwise results are truncated.
module fmul_seq_param #(
    parameter int EXP_W = 5,
    parameter int MAN_W = 10,
    parameter int BIAS  = (1 << (EXP_W - 1)) - 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_Valid,
    output logic             in_Ready,
    input  logic             in_Sign_1,
    input  logic [EXP_W-1:0] in_Exponent_1,
    input  logic [MAN_W-1:0] in_Mantissa_1,
    input  logic             in_Sign_2,
    input  logic [EXP_W-1:0] in_Exponent_2,
    input  logic [MAN_W-1:0] in_Mantissa_2,
    output logic             out_Valid,
    input  logic             out_Ready,
    output logic             out_Sign,
    output logic [EXP_W-1:0] out_Exponent,
    output logic [MAN_W-1:0] out_Mantissa,
    output logic             Exponent_Overflow,
    output logic             Exponent_Underflow
);
    localparam int PW = 2 * MAN_W + 2;
    localparam int CW = $clog2(MAN_W + 1);
    localparam logic [EXP_W+1:0] BIAS_X = (EXP_W + 2)'(BIAS);

    typedef enum logic [1:0] {IDLE, MULT, NORM, DONE} state_t;
    state_t state_q, state_d;

    logic             s1_q, s2_q;
    logic [EXP_W-1:0] e1_q, e2_q;
    logic [MAN_W-1:0] m1_q, m2_q;
    logic [PW-1:0]    mcand_q, acc_q;
    logic [MAN_W:0]   mplier_q;
    logic [CW-1:0]    cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (in_Valid) state_d = MULT;
            MULT:    if (cnt_q == CW'(MAN_W)) state_d = NORM;
            NORM:    state_d = DONE;
            DONE:    if (out_Ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign in_Ready  = (state_q == IDLE);
    assign out_Valid = (state_q == DONE);

    // Normalise so the leading one of the product always sits at bit PW-1.
    logic             prod_hi;
    logic [PW-1:0]    prod_n;
    logic [MAN_W-1:0] frac_t, frac_r;
    logic [EXP_W+1:0] e_raw, e_fin;
    logic             unused_bits;

    assign prod_hi = acc_q[PW-1];
    assign prod_n  = prod_hi ? acc_q : (acc_q << 1);
    assign frac_t  = prod_n[PW-2 -: MAN_W];
    assign e_raw   = {2'b00, e1_q} + {2'b00, e2_q} - BIAS_X + {{(EXP_W + 1){1'b0}}, prod_hi};

`ifdef FMUL_ROUND_NEAREST_EVEN_EN
    logic guard, sticky, round_up, carry;
    assign guard    = prod_n[MAN_W];
    assign sticky   = |prod_n[MAN_W-1:0];
    assign round_up = guard & (sticky | frac_t[0]);
    // An all-ones fraction rounding up wraps to zero and bumps the exponent.
    assign {carry, frac_r} = {1'b0, frac_t} + {{MAN_W{1'b0}}, round_up};
    assign e_fin       = e_raw + {{(EXP_W + 1){1'b0}}, carry};
    assign unused_bits = prod_n[PW-1];
`else
    assign frac_r      = frac_t;
    assign e_fin       = e_raw;
    assign unused_bits = ^{prod_n[PW-1], prod_n[MAN_W:0]};
`endif

    logic e1_max, e2_max, e1_zero, e2_zero, is_nan, is_inf, is_zero, ovf_cond, unf_cond;
    assign e1_max   = &e1_q;
    assign e2_max   = &e2_q;
    assign e1_zero  = ~|e1_q;
    assign e2_zero  = ~|e2_q;
    assign is_nan   = (e1_max & |m1_q) | (e2_max & |m2_q) | (e1_max & e2_zero) | (e2_max & e1_zero);
    assign is_inf   = e1_max | e2_max;
    assign is_zero  = e1_zero | e2_zero;
    assign ovf_cond = ~e_fin[EXP_W+1] & (e_fin[EXP_W:0] >= {1'b0, {EXP_W{1'b1}}});
    assign unf_cond = e_fin[EXP_W+1] | (e_fin == '0);

    logic [EXP_W-1:0] res_exp;
    logic [MAN_W-1:0] res_man;
    logic             res_ovf, res_unf;

    always_comb begin
        res_exp = e_fin[EXP_W-1:0];
        res_man = frac_r;
        res_ovf = 1'b0;
        res_unf = 1'b0;
        if (is_nan) begin
            res_exp = '1;
            res_man = {1'b1, {(MAN_W - 1){1'b0}}};
        end else if (is_inf) begin
            res_exp = '1;
            res_man = '0;
        end else if (is_zero) begin
            res_exp = '0;
            res_man = '0;
        end else if (ovf_cond) begin
            res_exp = '1;
            res_man = '0;
            res_ovf = 1'b1;
        end else if (unf_cond) begin
            res_exp = '0;
            res_man = '0;
            res_unf = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q <= 1'b0; s2_q <= 1'b0;
            e1_q <= '0;   e2_q <= '0;
            m1_q <= '0;   m2_q <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            out_Sign           <= 1'b0;
            out_Exponent       <= '0;
            out_Mantissa       <= '0;
            Exponent_Overflow  <= 1'b0;
            Exponent_Underflow <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (in_Valid) begin
                    s1_q <= in_Sign_1;     s2_q <= in_Sign_2;
                    e1_q <= in_Exponent_1; e2_q <= in_Exponent_2;
                    m1_q <= in_Mantissa_1; m2_q <= in_Mantissa_2;
                    mcand_q  <= {{(MAN_W + 1){1'b0}}, 1'b1, in_Mantissa_1};
                    mplier_q <= {1'b1, in_Mantissa_2};
                    acc_q    <= '0;
                    cnt_q    <= '0;
                end
                MULT: begin
                    if (mplier_q[0]) acc_q <= acc_q + mcand_q;
                    mcand_q  <= mcand_q << 1;
                    mplier_q <= mplier_q >> 1;
                    cnt_q    <= cnt_q + 1'b1;
                end
                NORM: begin
                    out_Sign           <= s1_q ^ s2_q;
                    out_Exponent       <= res_exp;
                    out_Mantissa       <= res_man;
                    Exponent_Overflow  <= res_ovf;
                    Exponent_Underflow <= res_unf;
                end
                DONE: if (out_Ready) begin
                    out_Sign           <= 1'b0;
                    out_Exponent       <= '0;
                    out_Mantissa       <= '0;
                    Exponent_Overflow  <= 1'b0;
                    Exponent_Underflow <= 1'b0;
                end
                default: ;
            endcase
        end
    end
endmodule
